// File: rtl/mips_exec_unit.sv
// MIPS execute stage: ALU, branch condition/target and jump target. Optional macro EXEC_OVF_TRAP_EN holds out_val on overflow.
// Latency: one cycle; every output is registered on the rising clock edge.
// Backpressure: none; enable=0 freezes all output registers, nop=1 inserts a bubble.
module mips_exec_unit (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        nop,
  input  logic [5:0]  alu_op,
  input  logic [4:0]  sa,
  input  logic [15:0] im,
  input  logic        sign_x,
  input  logic        mem_op,
  input  logic        br,
  input  logic        jp,
  input  logic        g_t,
  input  logic        link,
  input  logic [31:0] in_s1,
  input  logic [31:0] in_s2,
  input  logic [15:0] offset,
  input  logic [25:0] instr_idx,
  input  logic [31:0] pc,
  output logic [31:0] out_val,
  output logic [31:0] out_pc,
  output logic        zero,
  output logic        ovf
);

  logic [31:0] out_val_q, out_val_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;

  logic [31:0] pc_plus4, imm_sx, opb, sum, diff, alu_res, br_target, jmp_target;
  logic        alu_ovf, add_ovf, sub_ovf, cond, taken;

  // ALU datapath, branch evaluation and next-PC selection
  always_comb begin
    pc_plus4 = pc + 32'd4;
    imm_sx   = {{16{im[15]}}, im};
    // opcodes 0x38..0x3F take the extended immediate as second operand
    opb      = (alu_op[5:3] == 3'b111) ? (sign_x ? imm_sx : {16'h0000, im}) : in_s2;
    sum      = in_s1 + opb;
    diff     = in_s1 - opb;
    add_ovf  = (in_s1[31] == opb[31]) && (sum[31] != in_s1[31]);
    sub_ovf  = (in_s1[31] != opb[31]) && (diff[31] != in_s1[31]);

    alu_res = 32'h0;
    alu_ovf = 1'b0;
    case (alu_op)
      6'h20, 6'h38: begin alu_res = sum; alu_ovf = add_ovf; end
      6'h21, 6'h39: alu_res = sum;
      6'h22:        begin alu_res = diff; alu_ovf = sub_ovf; end
      6'h23:        alu_res = diff;
      6'h24, 6'h3C: alu_res = in_s1 & opb;
      6'h25, 6'h3D: alu_res = in_s1 | opb;
      6'h26, 6'h3E: alu_res = in_s1 ^ opb;
      6'h27:        alu_res = ~(in_s1 | opb);
      6'h2A, 6'h3A: alu_res = {31'd0, $signed(in_s1) < $signed(opb)};
      6'h2B, 6'h3B: alu_res = {31'd0, in_s1 < opb};
      6'h00:        alu_res = in_s2 << sa;
      6'h02:        alu_res = in_s2 >> sa;
      6'h03:        alu_res = 32'($signed(in_s2) >>> sa);
      6'h04:        alu_res = in_s2 << in_s1[4:0];
      6'h06:        alu_res = in_s2 >> in_s1[4:0];
      6'h07:        alu_res = 32'($signed(in_s2) >>> in_s1[4:0]);
      6'h3F:        alu_res = {im, 16'h0000};
      default:      alu_res = 32'h0;
    endcase
    // effective-address mode always sign-extends and never reports overflow
    if (mem_op) begin
      alu_res = in_s1 + imm_sx;
      alu_ovf = 1'b0;
    end

    case (alu_op)
      6'h04:   cond = (in_s1 == in_s2);
      6'h05:   cond = (in_s1 != in_s2);
      6'h06:   cond = in_s1[31] || (in_s1 == 32'h0);
      6'h07:   cond = !in_s1[31] && (in_s1 != 32'h0);
      6'h01:   cond = g_t ? !in_s1[31] : in_s1[31];
      default: cond = 1'b0;
    endcase
    taken     = br && cond;
    br_target = pc_plus4 + {{14{offset[15]}}, offset, 2'b00};

    case (alu_op)
      6'h02, 6'h03: jmp_target = {pc_plus4[31:28], instr_idx, 2'b00};
      6'h08, 6'h09: jmp_target = in_s1;
      default:      jmp_target = pc_plus4;
    endcase

    out_val_d = out_val_q;
    out_pc_d  = out_pc_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    if (enable) begin
      if (nop) begin
        out_val_d = 32'h0;
        out_pc_d  = pc_plus4;
        zero_d    = 1'b0;
        ovf_d     = 1'b0;
      end else begin
        zero_d    = taken;
        ovf_d     = alu_ovf;
        out_pc_d  = taken ? br_target : (jp ? jmp_target : pc_plus4);
        out_val_d = link ? pc_plus4 : alu_res;
`ifdef EXEC_OVF_TRAP_EN
        // trapping overflow leaves the previous result in place
        if (alu_ovf) out_val_d = out_val_q;
`endif
      end
    end
  end

  // output registers with asynchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_val_q <= 32'h0;
      out_pc_q  <= 32'h0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      out_val_q <= out_val_d;
      out_pc_q  <= out_pc_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_val = out_val_q;
  assign out_pc  = out_pc_q;
  assign zero    = zero_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_mips_exec_unit.sv
// Bench for mips_exec_unit: directed plan steps followed by randomized instructions.
// Each step is scored against a reference model evaluated once per enabled clock.
// Outputs are sampled 1 time unit after the rising edge.
module tb_mips_exec_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable, nop, sign_x, mem_op, br, jp, g_t, link;
  logic [5:0]  alu_op;
  logic [4:0]  sa;
  logic [15:0] im, offset;
  logic [25:0] instr_idx;
  logic [31:0] in_s1, in_s2, pc;
  logic [31:0] out_val, out_pc;
  logic        zero, ovf;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_val, m_pc;
  logic        m_zero, m_ovf;

  mips_exec_unit dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .nop(nop),
    .alu_op(alu_op), .sa(sa), .im(im), .sign_x(sign_x), .mem_op(mem_op),
    .br(br), .jp(jp), .g_t(g_t), .link(link), .in_s1(in_s1), .in_s2(in_s2),
    .offset(offset), .instr_idx(instr_idx), .pc(pc),
    .out_val(out_val), .out_pc(out_pc), .zero(zero), .ovf(ovf)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_val"}, out_val, m_val);
    chk({tag, ".out_pc"}, out_pc, m_pc);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, m_zero});
    chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, m_ovf});
  endtask

  // Reference: instruction semantics written as plain arithmetic on integers.
  task automatic model_update();
    logic [31:0] pc4, b, r, sx, newval;
    longint      s;
    bit          ov, cond, taken;
    if (!enable) return;
    pc4 = pc + 32'd4;
    if (nop) begin
      m_val = 32'h0; m_zero = 1'b0; m_ovf = 1'b0; m_pc = pc4;
      return;
    end
    sx = 32'($signed(im));
    b  = (alu_op >= 6'h38) ? (sign_x ? sx : {16'h0000, im}) : in_s2;
    r  = 32'h0;
    ov = 1'b0;
    s  = 0;
    case (alu_op)
      6'h20, 6'h38: begin
        s  = longint'($signed(in_s1)) + longint'($signed(b));
        r  = s[31:0];
        ov = (s != longint'($signed(r)));
      end
      6'h22: begin
        s  = longint'($signed(in_s1)) - longint'($signed(b));
        r  = s[31:0];
        ov = (s != longint'($signed(r)));
      end
      6'h21, 6'h39: r = in_s1 + b;
      6'h23:        r = in_s1 - b;
      6'h24, 6'h3C: r = in_s1 & b;
      6'h25, 6'h3D: r = in_s1 | b;
      6'h26, 6'h3E: r = in_s1 ^ b;
      6'h27:        r = ~(in_s1 | b);
      6'h2A, 6'h3A: r = ($signed(in_s1) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2B, 6'h3B: r = (in_s1 < b) ? 32'd1 : 32'd0;
      6'h00:        r = in_s2 << sa;
      6'h02:        r = in_s2 >> sa;
      6'h03:        r = 32'($signed(in_s2) >>> sa);
      6'h04:        r = in_s2 << in_s1[4:0];
      6'h06:        r = in_s2 >> in_s1[4:0];
      6'h07:        r = 32'($signed(in_s2) >>> in_s1[4:0]);
      6'h3F:        r = {16'h0000, im} * 32'd65536;
      default:      r = 32'h0;
    endcase
    if (mem_op) begin
      r  = in_s1 + sx;
      ov = 1'b0;
    end
    case (alu_op)
      6'h04:   cond = (in_s1 == in_s2);
      6'h05:   cond = (in_s1 != in_s2);
      6'h06:   cond = ($signed(in_s1) <= 0);
      6'h07:   cond = ($signed(in_s1) > 0);
      6'h01:   cond = g_t ? ($signed(in_s1) >= 0) : ($signed(in_s1) < 0);
      default: cond = 1'b0;
    endcase
    taken = br && cond;
    if (taken) m_pc = pc4 + 32'($signed(offset)) * 32'd4;
    else if (jp) begin
      case (alu_op)
        6'h02, 6'h03: m_pc = (pc4 & 32'hF000_0000) | ({6'd0, instr_idx} * 32'd4);
        6'h08, 6'h09: m_pc = in_s1;
        default:      m_pc = pc4;
      endcase
    end else m_pc = pc4;
    m_zero = taken;
    m_ovf  = ov;
    newval = link ? pc4 : r;
`ifdef EXEC_OVF_TRAP_EN
    if (!ov) m_val = newval;
`else
    m_val = newval;
`endif
  endtask

  task automatic clear_in();
    enable = 1'b1; nop = 1'b0; sign_x = 1'b0; mem_op = 1'b0; br = 1'b0; jp = 1'b0;
    g_t = 1'b0; link = 1'b0; alu_op = 6'h00; sa = 5'd0; im = 16'h0; offset = 16'h0;
    instr_idx = 26'h0; in_s1 = 32'h0; in_s2 = 32'h0; pc = 32'h0;
  endtask

  task automatic step(input string tag);
    model_update();
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] alu_codes[20] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                6'h38, 6'h39, 6'h3A, 6'h3F};
  logic [5:0] imm_codes[6]  = '{6'h3B, 6'h3C, 6'h3D, 6'h3E, 6'h3F, 6'h38};
  logic [5:0] br_codes[6]   = '{6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h10};
  logic [5:0] jp_codes[5]   = '{6'h02, 6'h03, 6'h08, 6'h09, 6'h11};

  initial begin
    clear_in();
    m_val = 32'h0; m_pc = 32'h0; m_zero = 1'b0; m_ovf = 1'b0;
    #1;
    check_all("reset_init");
    #8 reset_n = 1'b1;

    // ADD overflow
    clear_in(); alu_op = 6'h20; in_s1 = 32'h7FFF_FFFF; in_s2 = 32'h1; pc = 32'h40;
    step("add_ovf");
    // SRA
    clear_in(); alu_op = 6'h03; in_s2 = 32'h8000_0000; sa = 5'd4;
    step("sra");
    // ADDI sign-extended -1
    clear_in(); alu_op = 6'h38; im = 16'hFFFF; sign_x = 1'b1; in_s1 = 32'd5;
    step("addi");
    // ORI zero-extended
    clear_in(); alu_op = 6'h3D; im = 16'hFFFF;
    step("ori");
    // LUI
    clear_in(); alu_op = 6'h3F; im = 16'h1234; pc = 32'h2000;
    step("lui");

    // hold for 3 cycles with enable low while inputs change
    for (int i = 0; i < 3; i++) begin
      clear_in(); enable = 1'b0; alu_op = 6'h21; in_s1 = $urandom; in_s2 = $urandom;
      pc = $urandom; br = 1'b1;
      step("hold");
    end

    // effective address
    clear_in(); mem_op = 1'b1; alu_op = 6'h22; in_s1 = 32'h1000; im = 16'hFFFC;
    step("mem_op");
    // BEQ taken backwards
    clear_in(); br = 1'b1; alu_op = 6'h04; pc = 32'h100; in_s1 = 32'h55; in_s2 = 32'h55; offset = 16'hFFFE;
    step("beq");
    // BNE same operands
    alu_op = 6'h05;
    step("bne");
    // REGIMM BGEZ with zero operand
    clear_in(); br = 1'b1; alu_op = 6'h01; g_t = 1'b1; pc = 32'h300; offset = 16'h0010;
    step("bgez");
    // J
    clear_in(); jp = 1'b1; alu_op = 6'h02; pc = 32'h1000_0000; instr_idx = 26'h40;
    step("j");
    // JALR with link
    clear_in(); jp = 1'b1; alu_op = 6'h09; in_s1 = 32'h400; link = 1'b1; pc = 32'h200;
    step("jalr");
    // bubble over a taken branch
    clear_in(); nop = 1'b1; br = 1'b1; alu_op = 6'h04; pc = 32'h500; offset = 16'h0020;
    step("nop_br");
    // pc+4 wrap
    clear_in(); pc = 32'hFFFF_FFFC; alu_op = 6'h25; in_s1 = 32'hA5;
    step("pc_wrap");

    // asynchronous reset mid-cycle
    #3 reset_n = 1'b0;
    #1;
    m_val = 32'h0; m_pc = 32'h0; m_zero = 1'b0; m_ovf = 1'b0;
    check_all("reset_async");
    #2 reset_n = 1'b1;

    // randomized instruction mix
    for (int i = 0; i < 600; i++) begin
      clear_in();
      enable = ($urandom_range(0, 7) != 0);
      nop    = ($urandom_range(0, 9) == 0);
      in_s1  = rnd_op();
      in_s2  = ($urandom_range(0, 3) == 0) ? in_s1 : rnd_op();
      sa     = 5'($urandom);
      im     = 16'($urandom);
      sign_x = 1'($urandom);
      offset = 16'($urandom);
      instr_idx = 26'($urandom);
      pc     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      case ($urandom_range(0, 3))
        0: alu_op = alu_codes[$urandom_range(0, 19)];
        1: begin
          alu_op = imm_codes[$urandom_range(0, 5)];
          mem_op = ($urandom_range(0, 3) == 0);
          link   = mem_op && 1'($urandom);
        end
        2: begin
          br     = 1'b1;
          alu_op = br_codes[$urandom_range(0, 5)];
          g_t    = 1'($urandom);
          jp     = 1'($urandom);
          link   = 1'($urandom);
        end
        default: begin
          jp     = 1'b1;
          alu_op = jp_codes[$urandom_range(0, 4)];
          link   = 1'($urandom);
        end
      endcase
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_exec_unit.md
Name: mips_exec_unit

Overview:
- Single-cycle MIPS execute stage: integer ALU, conditional-branch evaluator and jump-target generator in one block.
- Produces the registered result value, branch-taken flag and next PC.
- Sits between decode/register-read and memory/writeback.
- All results are registered on the clock.

Parameters:
- none (datapath fixed at 32 bits)

Ports:
- clock  in  1  rising-edge clock (one clock domain)
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  update enable; 0 = all outputs hold
- nop  in  1  bubble; suppresses all computation
- alu_op  in  6  operation code (tables below)
- sa  in  5  shift amount
- im  in  16  immediate
- sign_x  in  1  immediate extension for immediate ALU ops; 1 = sign, 0 = zero
- mem_op  in  1  effective-address mode
- br  in  1  instruction is a conditional branch
- jp  in  1  instruction is a jump
- g_t  in  1  REGIMM select; 1 = BGEZ, 0 = BLTZ
- link  in  1  write pc+4 as result (JAL/JALR/link branches)
- in_s1  in  32  rs operand
- in_s2  in  32  rt operand
- offset  in  16  branch word offset
- instr_idx  in  26  jump index
- pc  in  32  current instruction address
- out_val  out  32  registered result
- out_pc  out  32  registered next PC
- zero  out  1  registered branch-taken flag
- ovf  out  1  registered signed-overflow flag

Behaviour:
- Reset (reset_n=0, async): out_val=0, out_pc=0, zero=0, ovf=0.
- Latency: one cycle. On a rising edge with enable=1, the combinational results below are captured. With enable=0, all outputs hold.
- nop=1 (and enable=1): out_val=0, zero=0, ovf=0, out_pc=pc+4. All other inputs are ignored.
- ALU result, register ops (B=in_s2), by alu_op:
  - 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR
  - 0x2A SLT (signed), 0x2B SLTU (result 1 or 0)
  - 0x00 SLL in_s2<<sa, 0x02 SRL, 0x03 SRA
  - 0x04 SLLV, 0x06 SRLV, 0x07 SRAV: amount = in_s1[4:0]
- ALU result, immediate ops (B=ext(im); ext = sign if sign_x else zero):
  - 0x38 ADDI, 0x39 ADDIU, 0x3A SLTI, 0x3B SLTIU
  - 0x3C ANDI, 0x3D ORI, 0x3E XORI
  - 0x3F LUI = {im,16'h0}
- Unlisted opcode: result 0.
- Arithmetic wraps modulo 2^32.
- ovf = signed overflow of ADD/SUB/ADDI only; 0 for all other ops.
- mem_op=1 overrides alu_op: result = in_s1 + sign-extend(im), ovf=0.
- Branch (br=1), condition by alu_op:
  - 0x04 BEQ in_s1==in_s2
  - 0x05 BNE in_s1!=in_s2
  - 0x06 BLEZ signed in_s1<=0
  - 0x07 BGTZ signed in_s1>0
  - 0x01 REGIMM: g_t=1 signed in_s1>=0, g_t=0 in_s1<0
  - other codes: not taken
  - zero = condition (0 when br=0)
  - target = pc+4 + (sign-extend(offset)<<2)
- Jump (jp=1) target by alu_op:
  - 0x02 J / 0x03 JAL: {pc_plus4[31:28], instr_idx, 2'b00}
  - 0x08 JR / 0x09 JALR: in_s1
  - other codes: pc+4
- Next PC priority:
  1. nop → pc+4
  2. br && condition → branch target
  3. jp → jump target
  4. otherwise pc+4
  - br and jp both set: the branch path is evaluated first.
- out_val = link ? pc+4 : ALU/mem result. link has priority over mem_op.
- pc+4 wraps at 32 bits (pc=0xFFFFFFFC → 0).

Optional Feature:
- Macro EXEC_OVF_TRAP_EN.
- Defined: when ovf=1 the out_val register is not updated (holds its previous value); ovf and out_pc update normally.
- Undefined: out_val always takes the wrapped result; ovf is still reported.

Test Plan:
- Reset: reset_n low mid-cycle → all outputs 0 immediately, no clock needed. enable=0 for 3 cycles → outputs hold.
- ALU ops:
  - ADD in_s1=0x7FFFFFFF, in_s2=1 → out_val=0x80000000, ovf=1 (macro off); with EXEC_OVF_TRAP_EN, out_val unchanged.
  - SRA in_s2=0x80000000, sa=4 → 0xF8000000.
  - ADDI im=0xFFFF, sign_x=1, in_s1=5 → 4.
  - ORI im=0xFFFF, sign_x=0, in_s1=0 → 0x0000FFFF.
  - LUI im=0x1234 → 0x12340000.
- mem_op: in_s1=0x1000, im=0xFFFC → out_val=0x00000FFC.
- Branches:
  - BEQ pc=0x100, equal operands, offset=0xFFFE → zero=1, out_pc=0xFC.
  - BNE same operands → zero=0, out_pc=0x104.
  - REGIMM g_t=1, in_s1=0 → taken.
- Jumps:
  - J pc=0x10000000, instr_idx=0x40 → out_pc=0x10000100.
  - JALR in_s1=0x400, link=1 → out_pc=0x400, out_val=pc+4.
- nop=1 with br=1 and taken condition → out_pc=pc+4, out_val=0, zero=0.
